// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: receiver FSM states and default frame geometry.
// The TX-side sequencer uses the same constants, so frames stay consistent on both ends.
package tdm_pkg;

    localparam int NUM_CH_DEF = 8;
    localparam int DATA_W_DEF = 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // A single-slot frame still needs a one-bit counter.
    function automatic int sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tdm_demux_1x8_if.sv
// Bundle between the serial-link side and the demultiplexer: slot stream in, rebuilt frame out.
interface tdm_demux_1x8_if
    import tdm_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = sel_width(NUM_CH)
) ();

    logic                       enable;
    logic [DATA_W-1:0]          in_data;
    logic                       in_valid;
    logic                       frame_sync;
    logic [SEL_W-1:0]           select_out;
    logic [NUM_CH*DATA_W-1:0]   out_bus;
    logic                       out_valid;
    logic                       frame_err;

    modport master (
        output enable,
        output in_data,
        output in_valid,
        output frame_sync,
        input  select_out,
        input  out_bus,
        input  out_valid,
        input  frame_err
    );

    modport slave (
        input  enable,
        input  in_data,
        input  in_valid,
        input  frame_sync,
        output select_out,
        output out_bus,
        output out_valid,
        output frame_err
    );

endinterface

// File: rtl/tdm_demux_1x8_slot_counter.sv
// Modulo-NUM_CH slot counter. clear together with inc restarts the frame at slot 1, which is
// what a resync needs: the sample carrying frame_sync has already filled slot 0.
module slot_counter
    import tdm_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [SEL_W-1:0] count,
    output logic             last
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0] count_reg;
    logic [SEL_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = inc ? SEL_W'(1) : '0;
        end else if (inc) begin
            count_next = (count_reg == LAST_SLOT) ? '0 : count_reg + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign last  = (count_reg == LAST_SLOT);

endmodule

// File: rtl/tdm_demux_1x8.sv
// TDM receiver: collects one sample per slot into a shadow frame and publishes the whole frame
// in a single update once the last slot arrives; a mid-frame sync drops the partial frame.
module tdm_demux_1x8
    import tdm_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic            clk,
    input  logic            reset,
    tdm_demux_1x8_if.slave  bus
);

    localparam int BUS_W = NUM_CH * DATA_W;

    state_t state_reg;
    state_t state_next;

    logic             accept;
    logic             capture;
    logic             complete;
    logic             err_next;
    logic             cnt_clear;
    logic             cnt_inc;
    logic [SEL_W-1:0] slot;
    logic             slot_last;
    logic [SEL_W-1:0] wr_idx;
    logic [NUM_CH-1:0] wr_en;

    logic [BUS_W-1:0] shadow_reg;
    logic [BUS_W-1:0] out_bus_reg;
    logic             out_valid_reg;
    logic             frame_err_reg;

    assign accept = bus.enable & bus.in_valid;

    slot_counter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_slot_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (slot),
        .last  (slot_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        complete   = 1'b0;
        err_next   = 1'b0;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state_reg)
            IDLE: begin
                // Samples without sync cannot be placed in a frame, so they are dropped silently.
                if (accept && bus.frame_sync) begin
                    capture    = 1'b1;
                    cnt_inc    = 1'b1;
                    state_next = RECV;
                end
            end
            RECV: begin
                if (accept) begin
                    capture = 1'b1;
                    cnt_inc = 1'b1;
                    if (bus.frame_sync) begin
                        err_next  = 1'b1;
                        cnt_clear = 1'b1;
                    end else if (slot_last) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A sync-qualified sample is always channel 0, whatever slot the counter had reached.
    assign wr_idx = bus.frame_sync ? '0 : slot;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_shadow
            assign wr_en[gi] = capture && (wr_idx == SEL_W'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_reg[gi*DATA_W +: DATA_W] <= '0;
                end else if (wr_en[gi]) begin
                    shadow_reg[gi*DATA_W +: DATA_W] <= bus.in_data;
                end
            end
        end
    endgenerate

    // The last channel bypasses the shadow so the frame is published on the edge that accepts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_bus_reg   <= '0;
            out_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            out_valid_reg <= complete;
            frame_err_reg <= err_next;
            if (complete) begin
                out_bus_reg <= {bus.in_data, shadow_reg[BUS_W-DATA_W-1:0]};
            end
        end
    end

    assign bus.select_out = slot;
    assign bus.out_bus    = out_bus_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.frame_err  = frame_err_reg;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Directed bench for the TDM receiver: stimulus queues expected frames and error pulses,
// a negedge monitor pops and compares them whenever the DUT pulses out_valid or frame_err.
module tb_tdm_demux_1x8;
    import tdm_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tdm_demux_1x8_if #(.NUM_CH(8), .DATA_W(1)) bus ();

    tdm_demux_1x8 #(.NUM_CH(8), .DATA_W(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int prev_vc  = -100;
    int last_vc  = -100;

    logic [7:0] exp_q[$];
    int         err_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor: decoupled from stimulus, consumes the scoreboard queues.
    always @(negedge clk) begin
        if (bus.out_valid || bus.frame_err) begin
            check("pulse_overlap", 32'(bus.out_valid & bus.frame_err), 32'd0);
        end
        if (bus.out_valid) begin
            n_valid++;
            prev_vc = last_vc;
            last_vc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out_valid: got out_bus %0h required no pulse", bus.out_bus);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                $display("frame out: out_bus=%02h expected=%02h cycle=%0d", bus.out_bus, e, cyc);
                check("out_bus", 32'(bus.out_bus), 32'(e));
            end
        end
        if (bus.frame_err) begin
            n_err++;
            if (err_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_frame_err: got pulse required none (cycle %0d)", cyc);
            end else begin
                void'(err_q.pop_front());
                $display("frame_err pulse cycle=%0d", cyc);
                n_checks++;
                n_pass++;
            end
        end
    end

    task automatic drive(input logic en, input logic v, input logic s, input logic d);
        @(posedge clk);
        #1;
        bus.enable     = en;
        bus.in_valid   = v;
        bus.frame_sync = s;
        bus.in_data    = d;
    endtask

    // Drive after checking select_out, which reflects the slots consumed so far.
    task automatic drive_chk(input logic en, input logic v, input logic s, input logic d,
                             input int sel_exp, input string name);
        @(posedge clk);
        #1;
        check(name, 32'(bus.select_out), 32'(sel_exp));
        bus.enable     = en;
        bus.in_valid   = v;
        bus.frame_sync = s;
        bus.in_data    = d;
    endtask

    task automatic send_frame(input logic [7:0] val, input logic [7:0] prev,
                              input int first_sel, input bit err);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("select_out", 32'(bus.select_out), (k == 0) ? 32'(first_sel) : 32'(k));
            check("out_bus_hold", 32'(bus.out_bus), 32'(prev));
            if (k == 0 && err) err_q.push_back(1);
            if (k == 7) exp_q.push_back(val);
            bus.enable     = 1'b1;
            bus.in_valid   = 1'b1;
            bus.frame_sync = (k == 0);
            bus.in_data    = val[k];
        end
        $display("frame in: %02h", val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.in_valid   = 1'b0;
        bus.frame_sync = 1'b0;
        bus.in_data    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_bus", 32'(bus.out_bus), 32'd0);
        check("rst_select", 32'(bus.select_out), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        reset = 1'b0;

        // 1: single frame 1,0,1,1,0,0,1,0 -> 4D
        send_frame(8'h4D, 8'h00, 0, 1'b0);
        drive_chk(1, 0, 0, 0, 0, "t1_sel_after");

        // 2: back-to-back A5, 3C
        send_frame(8'hA5, 8'h4D, 0, 1'b0);
        send_frame(8'h3C, 8'hA5, 0, 1'b0);
        drive(1, 0, 0, 0);
        @(negedge clk);
        #1;
        check("valid_spacing", 32'(last_vc - prev_vc), 32'd8);

        // 3: sync + 2 more samples, then resync with full FF frame
        drive_chk(1, 1, 1, 0, 0, "t3_sel0");
        drive_chk(1, 1, 0, 1, 1, "t3_sel1");
        drive_chk(1, 1, 0, 0, 2, "t3_sel2");
        send_frame(8'hFF, 8'h3C, 3, 1'b1);

        // 4: 81 with enable=0 stretch and in_valid gaps
        drive_chk(1, 1, 1, 1, 0, "t4_sel0");
        drive_chk(1, 1, 0, 0, 1, "t4_sel1");
        drive_chk(1, 1, 0, 0, 2, "t4_sel2");
        for (int k = 0; k < 4; k++) drive_chk(0, 1, (k == 0), 1, 3, "t4_frozen");
        for (int k = 0; k < 2; k++) drive_chk(1, 0, 1, 1, 3, "t4_gap");
        drive_chk(1, 1, 0, 0, 3, "t4_sel3");
        check("t4_bus_hold", 32'(bus.out_bus), 32'hFF);
        drive_chk(1, 1, 0, 0, 4, "t4_sel4");
        drive_chk(1, 1, 0, 0, 5, "t4_sel5");
        drive_chk(1, 1, 0, 0, 6, "t4_sel6");
        exp_q.push_back(8'h81);
        drive_chk(1, 1, 0, 1, 7, "t4_sel7");
        drive_chk(1, 0, 0, 0, 0, "t4_sel_after");

        // 5: idle noise
        drive_chk(1, 1, 0, 1, 0, "t5_valid_nosync");
        drive_chk(1, 0, 1, 1, 0, "t5_sync_novalid");
        drive_chk(1, 0, 0, 0, 0, "t5_sel_a");
        drive_chk(1, 0, 0, 0, 0, "t5_sel_b");
        check("t5_bus", 32'(bus.out_bus), 32'h81);

        // 6: reset after ch4, then 5A
        for (int k = 0; k < 5; k++) drive(1, 1, (k == 0), 1);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.frame_sync = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        check("t6_out_bus", 32'(bus.out_bus), 32'd0);
        check("t6_select", 32'(bus.select_out), 32'd0);
        check("t6_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_frame_err", 32'(bus.frame_err), 32'd0);
        send_frame(8'h5A, 8'h00, 0, 1'b0);

        repeat (3) drive(1, 0, 0, 0);
        @(negedge clk);
        #1;
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("err_q_empty", 32'(err_q.size()), 32'd0);
        check("valid_count", 32'(n_valid), 32'd6);
        check("err_count", 32'(n_err), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
